noc_inject_arbiter: RTL and testbench
=====================================

Name: noc_inject_arbiter

Overview:
- Wormhole packet arbiter sharing one router injection (sender) port among N_REQ local requesters, e.g. several PE/DMA sources feeding one NoC node.
- Round-robin grant on header flits; the grant is held until the granted packet's tail flit is accepted, so packets never interleave.
- One registered output stage drives the node's valid/ready/flit/is_header/is_tail interface and honours the node's VCready.

Parameters:
- N_REQ, 4, number of requesters (>= 2).
- DATA_WIDTH, 32, flit width; set equal to the project NoC flit width.
- IDW, $clog2(N_REQ), grant index width (derived, not overridden).

Ports:
- noc_clk  input  1  clock.
- noc_rst  input  1  reset, asynchronous, active-high.
- req_valid  input  N_REQ  per-requester flit valid.
- req_ready  output  N_REQ  per-requester flit accepted (valid & ready).
- req_flit  input  N_REQ*DATA_WIDTH  requester i flit at [i*DATA_WIDTH +: DATA_WIDTH].
- req_is_header  input  N_REQ  flit is a packet header.
- req_is_tail  input  N_REQ  flit is a packet tail; header and tail both high marks a single-flit packet.
- sender_valid  output  1  flit valid toward the router.
- sender_ready  input  1  router accepts the flit.
- sender_flit  output  DATA_WIDTH  flit to the router.
- sender_VCready  input  1  router has a free VC; gates new packets only.
- sender_is_header  output  1  header marker.
- sender_is_tail  output  1  tail marker.
- busy  output  1  packet lock held (state LOCK).
- grant_id  output  IDW  current or last granted requester.

Behaviour:
- Reset (async, noc_rst=1): state=IDLE, rr_ptr=0, grant_id=0, sender_valid=0, sender_flit=0, sender_is_header=0, sender_is_tail=0, busy=0, req_ready=0.
- slot_free = !sender_valid | sender_ready. The output register loads on any accept, otherwise holds. sender_valid clears when sender_ready is high and there is no new accept.
- Latency: flit accepted in cycle c appears on sender_* in cycle c+1. Throughput is 1 flit/cycle.
- While sender_valid=1 and sender_ready=0, all sender_* outputs hold stable and all req_ready=0.
- IDLE:
  - Candidates are requesters with req_valid & req_is_header.
  - If sender_VCready=1, slot_free=1 and at least one candidate exists, pick the first candidate searching rr_ptr, rr_ptr+1, ... modulo N_REQ. That winner g gets req_ready[g]=1 combinationally in the same cycle.
  - On accept, grant_id<=g.
  - If the flit is also a tail: stay IDLE, rr_ptr<=(g+1) mod N_REQ.
  - Otherwise: go to LOCK with owner=g, busy<=1.
- IDLE, non-header valid flits: never granted; req_ready stays 0 and the flit is left pending.
- LOCK:
  - req_ready[owner]=slot_free; all other req_ready=0.
  - sender_VCready is ignored for body/tail flits.
  - Header bits on owner flits are forwarded unchecked.
  - On accepting the owner's tail: go to IDLE, busy<=0, rr_ptr<=(owner+1) mod N_REQ.
  - The first new header can be accepted the cycle after the tail is accepted.
- Owner deasserting req_valid mid-packet: the lock is held indefinitely; no timeout.
- N_REQ not a power of 2: the pointer wraps from N_REQ-1 to 0; grant_id never exceeds N_REQ-1.
- Reset mid-packet: the partial packet in the output register is dropped. Upstream requesters and the router are reset by the same noc_rst.

Optional Feature:
- Macro: NOC_ARB_PKT_CNT_EN.
- When defined:
  - Adds output pkt_cnt, width N_REQ*16. Counter i sits at [i*16 +: 16].
  - Counter i increments by 1 on each accepted tail flit from requester i, including single-flit packets.
  - Wraps 16'hFFFF to 0. Reset value 0.
- When undefined: the port and counters are absent; all other behaviour is identical.

Test Plan:
- Req0 sends H,B,T (flits 0xA0,0xA1,0xA2), sender_ready=1, VCready=1 -> sender_flit 0xA0/0xA1/0xA2 on cycles c+1..c+3; is_header only on 0xA0, is_tail only on 0xA2; busy high from c+1 until the tail is accepted; grant_id=0.
- After reset, req1 and req3 present 2-flit headers simultaneously -> req1's packet is sent fully first, then req3's. Both contend again -> req3 is not granted; req1 wins (rr_ptr=0 after req3, search order 0,1) -> verify the order 1,3,1.
- Req0 4-flit packet locked, req2 header held valid throughout -> req_ready[2]=0 until the cycle after req0's tail is accepted; no req2 flit appears between req0 flits.
- sender_ready=0 for 3 cycles with sender_flit=0x55 valid -> sender_flit stays 0x55, req_ready all 0. Then sender_ready=1 -> the next flit appears the cycle after.
- Req0 header valid, sender_VCready=0 for 5 cycles -> no accept, sender_valid=0. VCready rises -> req_ready[0]=1 that cycle; header is on sender_flit the next cycle.
- noc_rst asserted mid-packet between clock edges -> sender_valid, busy and grant_id go to 0 immediately. After release, a new header from req1 is granted normally. With NOC_ARB_PKT_CNT_EN defined, pkt_cnt reads 0.

Source files
------------

// File: rtl/noc_inject_arbiter_if.sv
// ----------------------------------------------------------------------------
// noc_inject_arbiter_if
//
// Bundles the local requester side and the router sender side of the NoC
// injection arbiter.
//
//   req_valid/req_ready       per-requester flit handshake (N_REQ bits)
//   req_flit                  requester i flit at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_is_header/req_is_tail per-requester packet framing markers
//   sender_valid/sender_ready flit handshake toward the router
//   sender_flit               flit toward the router
//   sender_VCready            router has a free VC (gates new packets only)
//   sender_is_header/_is_tail framing markers toward the router
//
// Modports:
//   master  the arbiter (accepts requester flits, drives the router port)
//   slave   the environment (requesters plus router)
// ----------------------------------------------------------------------------
interface noc_inject_arbiter_if #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 32
);
    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ-1:0]            req_ready;
    logic [N_REQ*DATA_WIDTH-1:0] req_flit;
    logic [N_REQ-1:0]            req_is_header;
    logic [N_REQ-1:0]            req_is_tail;

    logic                        sender_valid;
    logic                        sender_ready;
    logic [DATA_WIDTH-1:0]       sender_flit;
    logic                        sender_VCready;
    logic                        sender_is_header;
    logic                        sender_is_tail;

    modport master (
        input  req_valid, req_flit, req_is_header, req_is_tail,
        input  sender_ready, sender_VCready,
        output req_ready,
        output sender_valid, sender_flit, sender_is_header, sender_is_tail
    );

    modport slave (
        output req_valid, req_flit, req_is_header, req_is_tail,
        output sender_ready, sender_VCready,
        input  req_ready,
        input  sender_valid, sender_flit, sender_is_header, sender_is_tail
    );
endinterface

// File: rtl/noc_inject_arbiter.sv
// ----------------------------------------------------------------------------
// noc_inject_arbiter
//
// Wormhole arbiter sharing one router injection port among N_REQ local
// requesters. New packets are granted round-robin on header flits; the grant
// is held until the owner's tail flit is accepted so packets never interleave.
// A single registered output stage feeds the router.
//
// Ports:
//   noc_clk   clock
//   noc_rst   asynchronous active-high reset
//   bus       noc_inject_arbiter_if.master (requester + router handshakes)
//   busy      packet lock held
//   grant_id  current or last granted requester
//   pkt_cnt   (only with NOC_ARB_PKT_CNT_EN) per-requester 16-bit count of
//             accepted tail flits, counter i at [i*16 +: 16], wrapping
//
// Optional feature macro: NOC_ARB_PKT_CNT_EN
// ----------------------------------------------------------------------------
module noc_inject_arbiter #(
    parameter int  N_REQ      = 4,
    parameter int  DATA_WIDTH = 32,
    localparam int IDW        = $clog2(N_REQ)
) (
    input  logic                   noc_clk,
    input  logic                   noc_rst,
    noc_inject_arbiter_if.master   bus,
    output logic                   busy,
    output logic [IDW-1:0]         grant_id
`ifdef NOC_ARB_PKT_CNT_EN
    ,
    output logic [N_REQ*16-1:0]    pkt_cnt
`endif
);

    typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

    state_t                  state_q, state_d;
    logic [IDW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]          grant_id_q, grant_id_d;
    logic                    sender_valid_q, sender_valid_d;
    logic [DATA_WIDTH-1:0]   sender_flit_q, sender_flit_d;
    logic                    sender_is_header_q, sender_is_header_d;
    logic                    sender_is_tail_q, sender_is_tail_d;

    logic                    slot_free;
    logic [N_REQ-1:0]        cand;
    logic                    win_found;
    logic [IDW-1:0]          win_idx;
    logic [IDW-1:0]          sel;
    logic                    accept;
    logic                    tail_accept;
    logic [N_REQ-1:0]        req_ready_c;
    logic [DATA_WIDTH-1:0]   flit_arr [N_REQ];

    // Unpack the flat flit bus so the selected flit is a plain array read.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign flit_arr[gi] = bus.req_flit[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    assign slot_free = !sender_valid_q || bus.sender_ready;
    assign cand      = bus.req_valid & bus.req_is_header;

    // Round-robin search starting at rr_ptr; the modulo keeps non-power-of-2
    // requester counts from ever selecting an index >= N_REQ.
    always_comb begin
        int unsigned idx;
        logic [IDW-1:0] idx_w;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        idx_w     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx   = (int'(rr_ptr_q) + k) % N_REQ;
            idx_w = IDW'(idx);
            if (!win_found && cand[idx_w]) begin
                win_found = 1'b1;
                win_idx   = idx_w;
            end
        end
    end

    always_comb begin
        state_d            = state_q;
        rr_ptr_d           = rr_ptr_q;
        grant_id_d         = grant_id_q;
        sender_valid_d     = sender_valid_q;
        sender_flit_d      = sender_flit_q;
        sender_is_header_d = sender_is_header_q;
        sender_is_tail_d   = sender_is_tail_q;
        req_ready_c        = '0;
        sel                = grant_id_q;
        accept             = 1'b0;

        // req_ready is combinational, so it is forced low while reset is held.
        if (!noc_rst) begin
            case (state_q)
                IDLE: begin
                    if (bus.sender_VCready && slot_free && win_found) begin
                        sel                  = win_idx;
                        req_ready_c[win_idx] = 1'b1;
                        accept               = 1'b1;
                    end
                end
                LOCK: begin
                    // Owner is grant_id_q; VC availability only gates new packets.
                    req_ready_c[grant_id_q] = slot_free;
                    accept                  = slot_free && bus.req_valid[grant_id_q];
                end
            endcase
        end

        tail_accept = accept && bus.req_is_tail[sel];

        if (accept) begin
            sender_valid_d     = 1'b1;
            sender_flit_d      = flit_arr[sel];
            sender_is_header_d = bus.req_is_header[sel];
            sender_is_tail_d   = bus.req_is_tail[sel];
            grant_id_d         = sel;
            if (tail_accept) begin
                state_d  = IDLE;
                rr_ptr_d = (32'(sel) == N_REQ - 1) ? '0 : sel + 1'b1;
            end else begin
                state_d  = LOCK;
            end
        end else if (bus.sender_ready) begin
            sender_valid_d = 1'b0;
        end
    end

    always_ff @(posedge noc_clk or posedge noc_rst) begin
        if (noc_rst) begin
            state_q            <= IDLE;
            rr_ptr_q           <= '0;
            grant_id_q         <= '0;
            sender_valid_q     <= 1'b0;
            sender_flit_q      <= '0;
            sender_is_header_q <= 1'b0;
            sender_is_tail_q   <= 1'b0;
        end else begin
            state_q            <= state_d;
            rr_ptr_q           <= rr_ptr_d;
            grant_id_q         <= grant_id_d;
            sender_valid_q     <= sender_valid_d;
            sender_flit_q      <= sender_flit_d;
            sender_is_header_q <= sender_is_header_d;
            sender_is_tail_q   <= sender_is_tail_d;
        end
    end

    assign bus.req_ready        = req_ready_c;
    assign bus.sender_valid     = sender_valid_q;
    assign bus.sender_flit      = sender_flit_q;
    assign bus.sender_is_header = sender_is_header_q;
    assign bus.sender_is_tail   = sender_is_tail_q;
    assign busy                 = (state_q == LOCK);
    assign grant_id             = grant_id_q;

`ifdef NOC_ARB_PKT_CNT_EN
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_pkt_cnt
            logic [15:0] cnt_q, cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (tail_accept && (sel == IDW'(gi))) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            always_ff @(posedge noc_clk or posedge noc_rst) begin
                if (noc_rst) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign pkt_cnt[gi*16 +: 16] = cnt_q;
        end
    endgenerate
`endif

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// ----------------------------------------------------------------------------
// tb_noc_inject_arbiter
//
// Directed scenarios followed by randomized traffic. A packet-level model
// (owner / round-robin pointer / output slot) predicts every output each
// cycle; literal expectations in the directed part pin that model.
// ----------------------------------------------------------------------------
module tb_noc_inject_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    noc_inject_arbiter_if #(.N_REQ(N), .DATA_WIDTH(DW)) bus ();
    logic       busy;
    logic [1:0] grant_id;
`ifdef NOC_ARB_PKT_CNT_EN
    logic [N*16-1:0] pkt_cnt;
`endif

    noc_inject_arbiter #(.N_REQ(N), .DATA_WIDTH(DW)) dut (
        .noc_clk  (clk),
        .noc_rst  (rst),
        .bus      (bus),
        .busy     (busy),
        .grant_id (grant_id)
`ifdef NOC_ARB_PKT_CNT_EN
        ,
        .pkt_cnt  (pkt_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Per-requester pending flits (head is what the requester presents)
    logic [31:0] qd [N][$];
    bit          qh [N][$];
    bit          qt [N][$];
    int          vprob = 100;

    logic [31:0] out_log [$];
    int          hdr_log [$];
    logic [N-1:0] last_ready;

    // Packet-level reference model
    bit           m_valid;
    logic [31:0]  m_flit;
    bit           m_hdr, m_tail;
    int           m_owner;    // -1 when no packet is in flight
    int           m_rr;
    int           m_gid;
    int unsigned  m_cnt [N];

    task automatic model_reset();
        m_valid = 0; m_flit = '0; m_hdr = 0; m_tail = 0;
        m_owner = -1; m_rr = 0; m_gid = 0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
    endtask

    function automatic logic [N-1:0] model_ready();
        logic [N-1:0] r;
        bit slot;
        r    = '0;
        slot = !m_valid || bus.sender_ready;
        if (m_owner < 0) begin
            if (bus.sender_VCready && slot) begin
                for (int k = 0; k < N; k++) begin
                    int i;
                    i = (m_rr + k) % N;
                    if (bus.req_valid[i] && bus.req_is_header[i]) begin
                        r[i] = 1'b1;
                        break;
                    end
                end
            end
        end else begin
            r[m_owner] = slot;
        end
        return r;
    endfunction

    task automatic add_pkt(input int i, input logic [31:0] base, input int len);
        for (int k = 0; k < len; k++) begin
            qd[i].push_back(base + 32'(k));
            qh[i].push_back(k == 0);
            qt[i].push_back(k == len - 1);
        end
    endtask

    task automatic drive_reqs();
        logic [N-1:0]    v, h, t;
        logic [N*DW-1:0] f;
        for (int i = 0; i < N; i++) begin
            if (qd[i].size() > 0) begin
                v[i] = ($urandom_range(99) < vprob);
                f[i*DW +: DW] = qd[i][0];
                h[i] = qh[i][0];
                t[i] = qt[i][0];
            end else begin
                v[i] = 1'b0;
                f[i*DW +: DW] = $urandom;
                h[i] = 1'($urandom_range(1));
                t[i] = 1'($urandom_range(1));
            end
        end
        bus.req_valid     = v;
        bus.req_flit      = f;
        bus.req_is_header = h;
        bus.req_is_tail   = t;
    endtask

    // One cycle: drive at negedge, compare at negedge+1, update model at posedge.
    task automatic step();
        logic [N-1:0] exp_r;
        int acc;
        drive_reqs();
        #1;
        exp_r      = model_ready();
        last_ready = bus.req_ready;
        chk("req_ready", bus.req_ready, exp_r);
        chk("sender_valid", bus.sender_valid, m_valid);
        if (m_valid) begin
            chk("sender_flit", bus.sender_flit, m_flit);
            chk("sender_is_header", bus.sender_is_header, m_hdr);
            chk("sender_is_tail", bus.sender_is_tail, m_tail);
        end
        chk("busy", busy, (m_owner >= 0));
        chk("grant_id", grant_id, m_gid);
`ifdef NOC_ARB_PKT_CNT_EN
        for (int i = 0; i < N; i++)
            chk("pkt_cnt", pkt_cnt[i*16 +: 16], m_cnt[i] & 32'hFFFF);
`endif
        if (bus.sender_valid && bus.sender_ready) begin
            out_log.push_back(bus.sender_flit);
            if (bus.sender_is_header) hdr_log.push_back(int'(bus.sender_flit[11:8]));
        end
        @(posedge clk);
        acc = -1;
        for (int i = 0; i < N; i++)
            if (exp_r[i] && bus.req_valid[i]) acc = i;
        if (acc >= 0) begin
            m_valid = 1;
            m_flit  = qd[acc][0];
            m_hdr   = qh[acc][0];
            m_tail  = qt[acc][0];
            m_gid   = acc;
            if (m_tail) begin
                m_owner = -1;
                m_rr    = (acc + 1) % N;
                m_cnt[acc]++;
            end else begin
                m_owner = acc;
            end
            void'(qd[acc].pop_front());
            void'(qh[acc].pop_front());
            void'(qt[acc].pop_front());
        end else if (bus.sender_ready) begin
            m_valid = 0;
        end
        @(negedge clk);
        $display("cyc acc=%0d out_v=%0b flit=%08h busy=%0b gid=%0d", acc, bus.sender_valid,
                 bus.sender_flit, busy, grant_id);
    endtask

    task automatic clear_queues();
        for (int i = 0; i < N; i++) begin
            qd[i].delete(); qh[i].delete(); qt[i].delete();
        end
    endtask

    initial begin
        logic [31:0] exp_c [6];
        int seq;
        model_reset();
        bus.req_valid      = '0;
        bus.req_flit       = '0;
        bus.req_is_header  = '0;
        bus.req_is_tail    = '0;
        bus.sender_ready   = 1'b1;
        bus.sender_VCready = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state, with a header offered so req_ready must be held low
        bus.req_valid     = 4'b0001;
        bus.req_is_header = 4'b0001;
        #1;
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_sender_valid", bus.sender_valid, 0);
        chk("rst_sender_flit", bus.sender_flit, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant_id", grant_id, 0);
        @(negedge clk);
        rst = 1'b0;

        // Three-flit packet from req0
        add_pkt(0, 32'hA0, 3);
        step();
        chk("A_flit0", bus.sender_flit, 32'hA0);
        chk("A_hdr0", bus.sender_is_header, 1);
        chk("A_tail0", bus.sender_is_tail, 0);
        chk("A_busy0", busy, 1);
        step();
        chk("A_flit1", bus.sender_flit, 32'hA1);
        chk("A_hdr1", bus.sender_is_header, 0);
        step();
        chk("A_flit2", bus.sender_flit, 32'hA2);
        chk("A_tail2", bus.sender_is_tail, 1);
        chk("A_busy2", busy, 0);
        chk("A_gid", grant_id, 0);
`ifdef NOC_ARB_PKT_CNT_EN
        chk("A_pkt_cnt0", pkt_cnt[15:0], 1);
`endif
        step();

        // req1 and req3 contend twice: order 1,3,1,3
        hdr_log.delete();
        add_pkt(1, 32'h110, 2); add_pkt(3, 32'h310, 2);
        add_pkt(1, 32'h120, 2); add_pkt(3, 32'h320, 2);
        repeat (12) step();
        chk("B_nhdr", hdr_log.size(), 4);
        if (hdr_log.size() >= 4) begin
            chk("B_order0", hdr_log[0], 1);
            chk("B_order1", hdr_log[1], 3);
            chk("B_order2", hdr_log[2], 1);
            chk("B_order3", hdr_log[3], 3);
        end

        // req0 locked for 4 flits while req2 header waits
        out_log.delete();
        add_pkt(0, 32'h0C0, 4); add_pkt(2, 32'h2C0, 2);
        repeat (10) step();
        exp_c = '{32'h0C0, 32'h0C1, 32'h0C2, 32'h0C3, 32'h2C0, 32'h2C1};
        chk("C_nflits", out_log.size(), 6);
        for (int k = 0; k < 6; k++)
            if (out_log.size() > k) chk("C_order", out_log[k], exp_c[k]);

        // Router stall with 0x55 held on the output
        add_pkt(0, 32'h55, 2);
        bus.sender_ready = 1'b1;
        step();
        bus.sender_ready = 1'b0;
        repeat (3) begin
            step();
            chk("D_hold_flit", bus.sender_flit, 32'h55);
            chk("D_hold_valid", bus.sender_valid, 1);
            chk("D_stall_ready", last_ready, 0);
        end
        bus.sender_ready = 1'b1;
        step();
        chk("D_resume_ready", last_ready, 4'b0001);
        chk("D_next_flit", bus.sender_flit, 32'h56);
        step();

        // No free VC: header is not accepted
        bus.sender_VCready = 1'b0;
        add_pkt(0, 32'h70, 1);
        repeat (5) begin
            step();
            chk("E_no_valid", bus.sender_valid, 0);
            chk("E_no_ready", last_ready, 0);
        end
        bus.sender_VCready = 1'b1;
        step();
        chk("E_ready", last_ready, 4'b0001);
        chk("E_flit", bus.sender_flit, 32'h70);
        step();

        // Asynchronous reset mid-packet
        add_pkt(2, 32'h2F0, 4);
        step(); step();
        chk("F_pre_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("F_rst_valid", bus.sender_valid, 0);
        chk("F_rst_busy", busy, 0);
        chk("F_rst_gid", grant_id, 0);
`ifdef NOC_ARB_PKT_CNT_EN
        chk("F_rst_pkt_cnt", pkt_cnt, 0);
`endif
        model_reset();
        clear_queues();
        bus.req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        add_pkt(1, 32'h1F0, 2);
        step();
        chk("F_gid", grant_id, 1);
        chk("F_flit", bus.sender_flit, 32'h1F0);
        step(); step();

        // Randomized traffic
        seq = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 200 == 0) vprob = $urandom_range(100, 40);
            for (int i = 0; i < N; i++) begin
                if (qd[i].size() == 0 && $urandom_range(9) == 0) begin
                    add_pkt(i, ($urandom & 32'hFFFF_F000) | 32'(i << 8) | 32'(seq & 8'hF0),
                            $urandom_range(5, 1));
                    seq += 16;
                end
            end
            bus.sender_ready   = ($urandom_range(99) < 75);
            bus.sender_VCready = ($urandom_range(99) < 70);
            step();
        end

        // Drain, bounded
        bus.sender_ready   = 1'b1;
        bus.sender_VCready = 1'b1;
        vprob = 100;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (qd[0].size() + qd[1].size() + qd[2].size() + qd[3].size() == 0) break;
            step();
        end
        for (int i = 0; i < N; i++) chk("drain_empty", qd[i].size(), 0);
        step(); step();
        chk("drain_idle", bus.sender_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
